// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic/arith ops, NBITS-cycle shift-add multiply
module alu_seq #(
    parameter int NBITS      = 8,
    parameter bit SIGNED_SLT = 1'b0
) (
    input  logic             clk_2,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] result,
    output logic [NBITS-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int CW = (NBITS > 2) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*NBITS-1:0] mcand;
    logic [NBITS-1:0]   mplier;
    logic [2*NBITS-1:0] acc;

    logic [NBITS:0]     sum_ext;
    logic [NBITS:0]     diff_ext;
    logic               lt;
    logic [NBITS-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [2*NBITS-1:0] acc_next;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Single-cycle datapath works straight off the input bundle; its result is captured on accept.
    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        if (SIGNED_SLT)
            lt = ($signed(a) < $signed(b));
        else
            lt = (a < b);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD: begin
                alu_res = sum_ext[NBITS-1:0];
                alu_c   = sum_ext[NBITS];
                alu_v   = (a[NBITS-1] == b[NBITS-1]) && (sum_ext[NBITS-1] != a[NBITS-1]);
            end
            OP_ANDN: alu_res = a & ~b;
            OP_ORN:  alu_res = a | ~b;
            OP_SUB: begin
                alu_res = diff_ext[NBITS-1:0];
                alu_c   = diff_ext[NBITS];
                alu_v   = (a[NBITS-1] != b[NBITS-1]) && (diff_ext[NBITS-1] != a[NBITS-1]);
            end
            OP_SLT:  alu_res = {{(NBITS-1){1'b0}}, lt};
            default: alu_res = '0;
        endcase
    end

    // The multiplier is consumed LSB first while the multiplicand shifts left alongside it.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            result    <= '0;
            result_hi <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            mcand  <= {{NBITS{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= S_MUL;
                        end else begin
                            result    <= alu_res;
                            result_hi <= '0;
                            flag_z    <= (alu_res == '0);
                            flag_n    <= alu_res[NBITS-1];
                            flag_c    <= alu_c;
                            flag_v    <= alu_v;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        result    <= acc_next[NBITS-1:0];
                        result_hi <= acc_next[2*NBITS-1:NBITS];
                        flag_z    <= (acc_next == '0);
                        flag_n    <= acc_next[2*NBITS-1];
                        flag_c    <= 1'b0;
                        flag_v    <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter NBITS, default 8: operand and result width; legal range 2..32.
REQ-002 Parameter SIGNED_SLT, default 0: 0 = unsigned SLT compare, 1 = two's-complement compare.
REQ-003 clk_2  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk_2.
REQ-005 in_valid  input  1  operand/opcode bundle valid.
REQ-006 in_ready  output  1  block can accept a bundle.
REQ-007 op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 MUL, 100 ANDN, 101 ORN, 110 SUB, 111 SLT.
REQ-008 a, b  input  NBITS each  operands.
REQ-009 out_valid  output  1  result bundle valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  NBITS  result; low half for MUL.
REQ-012 result_hi  output  NBITS  high half of the MUL product; 0 for every other op.
REQ-013 flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative, carry/borrow and signed-overflow flags.

Function
REQ-014 FSM states: IDLE, MUL, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Accept is in_valid && in_ready at a rising edge; a, b and op are captured into internal registers on accept.
REQ-016 Changes on a, b and op after accept have no effect on the operation in flight.
REQ-017 Non-MUL ops: IDLE->DONE on accept; result and flags are registered on the same edge, so out_valid rises 1 cycle after accept.
REQ-018 ANDN = a & ~b and ORN = a | ~b, both bitwise over all NBITS.
REQ-019 ADD and SUB wrap modulo 2^NBITS.
REQ-020 SLT: result = {NBITS-1 zeros, lt}, where lt uses the compare selected by SIGNED_SLT.
REQ-021 MUL is an unsigned shift-add multiply, one multiplier bit per cycle.
REQ-022 MUL states: IDLE->MUL on accept; MUL holds for exactly NBITS cycles, with an internal counter running 0..NBITS-1; MUL->DONE when the counter reaches NBITS-1.
REQ-023 MUL: out_valid rises NBITS+1 cycles after accept; {result_hi,result} = a*b (2*NBITS bits, exact).
REQ-024 flag_z = (result==0); for MUL, flag_z = ({result_hi,result}==0).
REQ-025 flag_n = MSB of result; for MUL, MSB of result_hi.
REQ-026 flag_c: ADD = carry-out; SUB = borrow (a<b unsigned); 0 for all other ops.
REQ-027 flag_v: ADD/SUB signed overflow; 0 for all other ops.
REQ-028 DONE holds result and all flags stable while out_ready=0; no timeout.
REQ-029 DONE->IDLE when out_valid && out_ready; outputs keep their values until the next operation completes.
REQ-030 in_ready is low during MUL and DONE, so in_valid is ignored there; minimum throughput is one op per 2 cycles.
REQ-031 in_valid arriving on the same edge as the DONE->IDLE transition is not accepted; it is accepted on the following edge.

Reset
REQ-032 rst_n=0 at a rising edge forces state=IDLE, MUL counter=0, result=0, result_hi=0 and all flags=0.
REQ-033 After that reset edge, out_valid=0 and in_ready=1.
REQ-034 Reset mid-MUL or in DONE discards the operation; no out_valid is produced for it.
REQ-035 Reset has priority over accept and over the output handshake on the same edge.

Verification (NBITS=8 unless noted)
REQ-036 ADD a=0xFF b=0x01 -> 1 cycle later: result 0x00, z=1, c=1, v=0, n=0.
REQ-037 SUB a=0x80 b=0x01 -> result 0x7F, v=1, c=0, n=0; SUB a=0x01 b=0x02 -> result 0xFF, c=1, n=1.
REQ-038 MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept; result_hi=0xFE, result=0x01, in_ready=0 throughout.
REQ-039 SLT a=0x80 b=0x01: SIGNED_SLT=0 -> result 0x00; SIGNED_SLT=1 -> result 0x01. ANDN a=0xF0 b=0x30 -> 0xC0.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles after an ORN -> result/flags stable and in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-041 Assert rst_n=0 on cycle 4 of a MUL -> next cycle IDLE with all outputs 0; a fresh ADD then completes normally.
